picorv32_alu_pipe_elastic: RTL
==============================

# picorv32_alu_pipe_elastic

Parametrised, elastic successor to the fixed 5-stage ALU pipeline. Each accepted instruction carries its own operands down the pipe, so opcode and data stay aligned. The block adds valid/ready backpressure, synchronous flush, illegal-op flagging and occupancy reporting. It sits between the decode/issue logic and the writeback arbiter of the simplified PicoRV32 datapath.

## Interface
Parameters:
- XLEN, 32, datapath width; power of two, ≥ 8
- DEPTH, 5, number of register stages from accept to output; ≥ 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  block can accept this cycle
- instr  in  32  instruction; opcode = instr[3:0]
- a  in  XLEN  operand A, sampled with instr
- b  in  XLEN  operand B, sampled with instr
- flush  in  1  synchronous kill of all in-flight entries
- out_valid  out  1  result present at final stage
- out_ready  in  1  downstream accepts the result
- result  out  XLEN  ALU result of final stage
- out_illegal  out  1  final-stage opcode was unsupported
- out_op  out  4  opcode of final-stage entry
- occupancy  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- Stages S1..S_DEPTH, each with a valid bit, op, and payload. S1 holds {op, a, b}. S2..S_DEPTH hold {op, result, illegal}.
- ALU is combinational between S1 and S2. Later stages are pass-through.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount = b[$clog2(XLEN)-1:0]
  - 8 SLT (signed), 9 SLTU; both yield 1 or 0, zero-extended
- Opcodes 10–15: result = 0, illegal = 1.
- Arithmetic wraps modulo 2^XLEN; no carry or overflow output.
- Stage advance rule:
  - Sk moves into Sk+1 when Sk+1 is empty or Sk+1 is itself advancing.
  - S_DEPTH drains when out_valid && out_ready.
- in_ready = !flush && (S1 empty || S1 advancing). The ready chain is combinational from out_ready (no skid buffer).
- Accept occurs on in_valid && in_ready; the entry is loaded into S1 at that edge.
- A stage not advancing holds its payload. Bubbles never overwrite held data.
- flush:
  - At the next edge, all valid bits clear; occupancy becomes 0.
  - No accept occurs that cycle.
  - An out handshake in the flush cycle still counts as delivered.
- occupancy is registered and equals the popcount of stage valid bits after each edge.
- Outputs result, out_op and out_illegal are driven from S_DEPTH registers. Their values are meaningful only while out_valid = 1.

## Timing
- Reset (async assert, any time, mid-transfer included):
  - All valid bits, payloads, result, out_op, out_illegal and occupancy go to 0 immediately.
  - in_ready = 1 after reset release (flush low).
- Latency: an entry accepted in cycle c, with no stalls, has out_valid = 1 in cycle c+DEPTH. For the default this is c+5.
- Throughput: 1 entry per cycle while out_ready = 1.
- Full pipe with out_ready = 0: all stages hold, in_ready = 0, occupancy = DEPTH.
- Full pipe with out_ready = 1: the pipe shifts and in_ready = 1 in the same cycle. Simultaneous accept and drain keeps occupancy unchanged.
- Order is strictly preserved; no entry is dropped or duplicated except by flush or rst.
- Bubbles do not collapse unless a downstream stage is blocked. Stage k advances into an empty k+1 regardless of upstream state.

## Test plan
- Reset then stream, DEPTH=5: ADD a=5 b=7, SUB a=3 b=5, SRA a=0x80000000 b=4 accepted in cycles 1,2,3.
  - Results 12, 0xFFFFFFFE, 0xF8000000 appear in cycles 6,7,8.
  - out_op = 0,1,7.
- Backpressure: fill with 5 ADDs (values 1..5 + 0), hold out_ready = 0 for 4 cycles.
  - occupancy = 5, in_ready = 0, result stable at 1.
  - Release: results 1..5 over consecutive cycles with no loss.
- Illegal and compare: op 12 gives result 0 and out_illegal = 1. SLT a=0xFFFFFFFF b=1 gives 1. SLTU with the same operands gives 0.
- Flush mid-stream: flush asserted with 3 entries in flight.
  - Next cycle out_valid = 0 and occupancy = 0.
  - An entry presented during the flush cycle is not accepted (in_ready = 0).
- Async reset during a stalled full pipe: all outputs 0 within the reset assertion. No stale result appears after release.
- Parameter sweep XLEN=8, DEPTH=2:
  - SLL a=0x01 b=0x0F (shamt 7) gives 0x80, two cycles after accept.
  - ADD 0xFF+0x01 gives 0x00.

Source files
------------

// File: rtl/picorv32_alu_pipe_elastic.sv
// rtl/picorv32_alu_pipe_elastic.sv - elastic ALU pipeline with valid/ready backpressure, flush and occupancy
module picorv32_alu_pipe_elastic #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  instr,
    input  logic [XLEN-1:0]              a,
    input  logic [XLEN-1:0]              b,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              result,
    output logic                         out_illegal,
    output logic [3:0]                   out_op,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int SHW = $clog2(XLEN);
    localparam int OW  = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q, valid_d, adv, load;
    logic             accept;
    logic [OW-1:0]    occ_q, occ_d;

    logic [3:0]       s1_op_q;
    logic [XLEN-1:0]  s1_a_q, s1_b_q;
    logic [3:0]       op_q  [1:DEPTH-1];
    logic [XLEN-1:0]  res_q [1:DEPTH-1];
    logic [DEPTH-1:1] ill_q;

    logic [XLEN-1:0]  alu_res;
    logic             alu_ill;
    logic [SHW-1:0]   shamt;

    logic             unused_instr;
    assign unused_instr = ^instr[31:4];

    // Ready ripples back from out_ready: a stage moves if the next one is empty or moving.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = valid_q[DEPTH-1] && out_ready;
        for (int k = DEPTH-2; k >= 0; k--) begin
            adv[k] = valid_q[k] && (!valid_q[k+1] || adv[k+1]);
        end
    end

    assign in_ready = !flush && (!valid_q[0] || adv[0]);
    assign accept   = in_valid && in_ready;

    // load[k]: stage k captures new contents at this edge.
    always_comb begin
        load    = flush ? '0 : {adv[DEPTH-2:0], accept};
        valid_d = flush ? '0 : (load | (valid_q & ~adv));
        occ_d   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OW'(valid_d[k]);
        end
    end

    assign shamt = s1_b_q[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (s1_op_q)
            4'd0:    alu_res = s1_a_q + s1_b_q;
            4'd1:    alu_res = s1_a_q - s1_b_q;
            4'd2:    alu_res = s1_a_q & s1_b_q;
            4'd3:    alu_res = s1_a_q | s1_b_q;
            4'd4:    alu_res = s1_a_q ^ s1_b_q;
            4'd5:    alu_res = s1_a_q << shamt;
            4'd6:    alu_res = s1_a_q >> shamt;
            4'd7:    alu_res = $unsigned($signed(s1_a_q) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, s1_a_q < s1_b_q};
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            s1_op_q <= '0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            ill_q   <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                op_q[k]  <= '0;
                res_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            if (load[0]) begin
                s1_op_q <= instr[3:0];
                s1_a_q  <= a;
                s1_b_q  <= b;
            end
            if (load[1]) begin
                op_q[1]  <= s1_op_q;
                res_q[1] <= alu_res;
                ill_q[1] <= alu_ill;
            end
            for (int k = 2; k < DEPTH; k++) begin
                if (load[k]) begin
                    op_q[k]  <= op_q[k-1];
                    res_q[k] <= res_q[k-1];
                    ill_q[k] <= ill_q[k-1];
                end
            end
        end
    end

    assign out_valid   = valid_q[DEPTH-1];
    assign result      = res_q[DEPTH-1];
    assign out_op      = op_q[DEPTH-1];
    assign out_illegal = ill_q[DEPTH-1];
    assign occupancy   = occ_q;
endmodule
